// File: rtl/channel_trace_renderer_if.sv
// Pixel/mapper inputs, sample-RAM port and VGA outputs of channel_trace_renderer.
// master = pixel source + sample RAM side, slave = renderer.
interface channel_trace_renderer_if #(
   parameter int MAX_CHAN_COUNT = 10,
   parameter int ADDR_W         = 10,
   parameter int COL_W          = 10,
   parameter int ROW_W          = 9
);
   localparam int CH_W = $clog2(MAX_CHAN_COUNT);

   logic [COL_W-1:0]          pixel_col;
   logic [ROW_W-1:0]          pixel_row;
   logic                      video_on;
   logic                      hsync_in;
   logic                      vsync_in;
   logic                      is_channel;
   logic [CH_W-1:0]           channel_number;
   logic [ROW_W-1:0]          channel_height;
   logic [ROW_W-1:0]          channel_offset;
   logic [ADDR_W-1:0]         scroll_offset;
   logic [ADDR_W-1:0]         sample_addr;
   logic [MAX_CHAN_COUNT-1:0] sample_data;
   logic [11:0]               rgb;
   logic                      hsync_out;
   logic                      vsync_out;

   modport master (
      output pixel_col, pixel_row, video_on, hsync_in, vsync_in, is_channel,
             channel_number, channel_height, channel_offset, scroll_offset, sample_data,
      input  sample_addr, rgb, hsync_out, vsync_out
   );

   modport slave (
      input  pixel_col, pixel_row, video_on, hsync_in, vsync_in, is_channel,
             channel_number, channel_height, channel_offset, scroll_offset, sample_data,
      output sample_addr, rgb, hsync_out, vsync_out
   );
endinterface

// File: rtl/channel_trace_renderer.sv
// Draws one digital waveform per channel lane from capture RAM, 2-clock pixel latency.
// Optional grid overlay enabled by defining CHANNEL_TRACE_GRID_EN.
module channel_trace_renderer #(
   parameter int          MAX_CHAN_COUNT = 10,
   parameter int          ADDR_W         = 10,
   parameter int          COL_W          = 10,
   parameter int          VGA_VER_RES    = 480,
   parameter int          MARGIN         = 4,
   parameter logic [11:0] TRACE_COLOR    = 12'h0F0,
   parameter logic [11:0] SEP_COLOR      = 12'h444,
   parameter logic [11:0] GRID_COLOR     = 12'h222
) (
   input logic                      clk,
   input logic                      reset,
   channel_trace_renderer_if.slave  bus
);
   localparam int ROW_W = $clog2(VGA_VER_RES);
   localparam int CH_W  = $clog2(MAX_CHAN_COUNT);

   // Returns {hi, lo}; short lanes drop the margin and use their full height.
   function automatic logic [2*ROW_W-1:0] rail_limits(input logic [ROW_W-1:0] height);
      logic [ROW_W-1:0] hi;
      logic [ROW_W-1:0] lo;
      if (height < ROW_W'(2*MARGIN+2)) begin
         hi = '0;
         lo = height - ROW_W'(1);
      end else begin
         hi = ROW_W'(MARGIN);
         lo = height - ROW_W'(1) - ROW_W'(MARGIN);
      end
      return {hi, lo};
   endfunction

   logic [ADDR_W-1:0] scroll_q;
   logic [ROW_W-1:0]  lr_p1;
   logic [ROW_W-1:0]  height_p1;
   logic [CH_W-1:0]   ch_p1;
   logic              isch_p1;
   logic              vld_p1;
   logic              col0_p1;
   logic              hs_p1;
   logic              vs_p1;
   logic              prev_bit;
   logic [11:0]       rgb_p2;
   logic              hs_p2;
   logic              vs_p2;

   // S0: address the sample RAM for this column
   assign bus.sample_addr = ADDR_W'(bus.pixel_col) + scroll_q;

   // S1: sample bit is available, decide the pixel colour
   logic             bit_p1;
   logic [ROW_W-1:0] hi_p1;
   logic [ROW_W-1:0] lo_p1;
   logic             edge_p1;
   logic             trace_p1;
   logic             grid_hit;
   logic [11:0]      rgb_nxt;

   assign bit_p1         = bus.sample_data[ch_p1];
   assign {hi_p1, lo_p1} = rail_limits(height_p1);
   assign edge_p1        = (bit_p1 != prev_bit) && !col0_p1;
   assign trace_p1       = (bit_p1 && (lr_p1 == hi_p1)) ||
                           (!bit_p1 && (lr_p1 == lo_p1)) ||
                           (edge_p1 && (lr_p1 >= hi_p1) && (lr_p1 <= lo_p1));

`ifdef CHANNEL_TRACE_GRID_EN
   logic grid_p1;
   assign grid_hit = grid_p1;
`else
   assign grid_hit = 1'b0;
`endif

   always_comb begin
      rgb_nxt = 12'h000;
      if (!vld_p1 || !isch_p1)
         rgb_nxt = 12'h000;
      else if (trace_p1)
         rgb_nxt = TRACE_COLOR;
      else if ((lr_p1 == '0) && (ch_p1 != '0))
         rgb_nxt = SEP_COLOR;
      else if (grid_hit)
         rgb_nxt = GRID_COLOR;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         scroll_q  <= '0;
         lr_p1     <= '0;
         height_p1 <= '0;
         ch_p1     <= '0;
         isch_p1   <= 1'b0;
         vld_p1    <= 1'b0;
         col0_p1   <= 1'b0;
         hs_p1     <= 1'b1;
         vs_p1     <= 1'b1;
         prev_bit  <= 1'b0;
         rgb_p2    <= 12'h000;
         hs_p2     <= 1'b1;
         vs_p2     <= 1'b1;
      end else begin
         // vs_p1 is last cycle's vsync_in, so this catches the falling edge
         if (vs_p1 && !bus.vsync_in)
            scroll_q <= bus.scroll_offset;
         // S0 -> S1
         lr_p1     <= bus.pixel_row - bus.channel_offset;
         height_p1 <= bus.channel_height;
         ch_p1     <= bus.channel_number;
         isch_p1   <= bus.is_channel;
         vld_p1    <= bus.video_on;
         col0_p1   <= (bus.pixel_col == '0);
         hs_p1     <= bus.hsync_in;
         vs_p1     <= bus.vsync_in;
         if (vld_p1)
            prev_bit <= bit_p1;
         // S1 -> S2
         rgb_p2    <= rgb_nxt;
         hs_p2     <= hs_p1;
         vs_p2     <= vs_p1;
      end
   end

`ifdef CHANNEL_TRACE_GRID_EN
   always_ff @(posedge clk) begin
      if (reset)
         grid_p1 <= 1'b0;
      else
         grid_p1 <= (bus.pixel_col[4:0] == 5'd0);
   end
`endif

   assign bus.rgb       = rgb_p2;
   assign bus.hsync_out = hs_p2;
   assign bus.vsync_out = vs_p2;
endmodule

// File: tb/tb_channel_trace_renderer.sv
// Directed-vector bench for channel_trace_renderer with a 1-cycle-latency sample RAM model.
module tb_channel_trace_renderer;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Per-pixel fields applied by feed()
   logic vid;
   logic isch;
   int   ch;
   int   ch_h;
   int   ch_off;

   logic [9:0] mem [0:1023];

   channel_trace_renderer_if #(.MAX_CHAN_COUNT(10), .ADDR_W(10), .COL_W(10), .ROW_W(9)) bus ();

   channel_trace_renderer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) bus.sample_data <= mem[bus.sample_addr];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one pixel for a single cycle, then idle until its rgb is out.
   task automatic feed(input int col, input int row);
      bus.pixel_col      = 10'(col);
      bus.pixel_row      = 9'(row);
      bus.video_on       = vid;
      bus.is_channel     = isch;
      bus.channel_number = 4'(ch);
      bus.channel_height = 9'(ch_h);
      bus.channel_offset = 9'(ch_off);
      @(posedge clk); #1;
      bus.video_on = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic render(input string tag, input int col, input int row, input logic [11:0] exp);
      feed(col, row);
      check_eq(tag, 32'(bus.rgb), 32'(exp));
   endtask

   initial begin
      logic [11:0] grid_exp;
`ifdef CHANNEL_TRACE_GRID_EN
      grid_exp = 12'h222;
`else
      grid_exp = 12'h000;
`endif
      for (int a = 0; a < 1024; a++) mem[a] = 10'h001;
      reset = 1'b1;
      vid = 1'b0; isch = 1'b1; ch = 0; ch_h = 480; ch_off = 0;
      bus.pixel_col = '0; bus.pixel_row = '0; bus.video_on = 1'b0;
      bus.hsync_in = 1'b1; bus.vsync_in = 1'b1; bus.is_channel = 1'b0;
      bus.channel_number = '0; bus.channel_height = '0; bus.channel_offset = '0;
      bus.scroll_offset = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_rgb", 32'(bus.rgb), 32'h000);
      check_eq("rst_hsync", 32'(bus.hsync_out), 32'd1);
      check_eq("rst_vsync", 32'(bus.vsync_out), 32'd1);
      reset = 1'b0;
      bus.pixel_col = 10'd7;
      #1;
      check_eq("rst_scroll_addr", 32'(bus.sample_addr), 32'd7);
      @(posedge clk); #1;

      // Single full-height lane, bit0 constantly high
      vid = 1'b1; isch = 1'b1; ch = 0; ch_h = 480; ch_off = 0;
      render("hi_rail", 5, 4, 12'h0F0);
      render("row475_blank", 6, 475, 12'h000);
      render("top_lane_no_sep", 7, 0, 12'h000);
      ch = 1; ch_h = 48; ch_off = 48;
      render("separator", 8, 48, 12'h444);
      render("lo_rail_ch1", 8, 91, 12'h0F0);
      ch = 0; ch_h = 8; ch_off = 0;
      render("short_lane_hi0", 9, 0, 12'h0F0);
      ch = 1; ch_h = 8; ch_off = 48;
      render("short_lane_lo7", 9, 55, 12'h0F0);

      // Rising edge at column 10 in a 48-row lane
      for (int a = 0; a < 1024; a++) mem[a] = (a >= 10) ? 10'h3FF : 10'h000;
      ch = 0; ch_h = 48; ch_off = 0;
      render("col9_lo_rail", 9, 43, 12'h0F0);
      feed(9, 4);  render("edge_row4", 10, 4, 12'h0F0);
      feed(9, 20); render("edge_row20", 10, 20, 12'h0F0);
      feed(9, 43); render("edge_row43", 10, 43, 12'h0F0);
      feed(9, 3);  render("edge_above_rail", 10, 3, 12'h000);
      feed(10, 20); render("col0_no_edge", 0, 20, 12'h000);

      // Blanking and non-lane rows
      feed(11, 20);
      vid = 1'b0; render("video_off", 12, 4, 12'h000);
      vid = 1'b1; isch = 1'b0; render("not_channel", 12, 4, 12'h000);
      isch = 1'b1;

      // Grid column inside a lane
      feed(31, 20);
      render("grid_col32", 32, 20, grid_exp);

      // Scroll latch on vsync fall, plus 2-clock sync delay
      vid = 1'b0;
      bus.scroll_offset = 10'd1020;
      bus.vsync_in = 1'b0;
      @(posedge clk); #1;
      check_eq("vsync_lag1", 32'(bus.vsync_out), 32'd1);
      bus.vsync_in = 1'b1;
      @(posedge clk); #1;
      check_eq("vsync_lag2", 32'(bus.vsync_out), 32'd0);
      @(posedge clk); #1;
      check_eq("vsync_lag3", 32'(bus.vsync_out), 32'd1);
      for (int c = 0; c < 6; c++) begin
         bus.pixel_col = 10'(c);
         #1;
         check_eq($sformatf("addr_col%0d", c), 32'(bus.sample_addr), 32'((1020 + c) % 1024));
      end
      bus.scroll_offset = 10'd5;
      @(posedge clk); #1;
      bus.pixel_col = 10'd0;
      #1;
      check_eq("scroll_held", 32'(bus.sample_addr), 32'd1020);
      bus.vsync_in = 1'b0;
      @(posedge clk); #1;
      bus.vsync_in = 1'b1;
      #1;
      check_eq("scroll_next_frame", 32'(bus.sample_addr), 32'd5);
      bus.hsync_in = 1'b0;
      @(posedge clk); #1;
      check_eq("hsync_lag1", 32'(bus.hsync_out), 32'd1);
      bus.hsync_in = 1'b1;
      @(posedge clk); #1;
      check_eq("hsync_lag2", 32'(bus.hsync_out), 32'd0);
      @(posedge clk); #1;
      check_eq("hsync_lag3", 32'(bus.hsync_out), 32'd1);

      // Reset while a trace pixel is in flight (col 0 + scroll 5 -> bit 0, lo rail)
      bus.pixel_col = 10'd0; bus.pixel_row = 9'd43; bus.video_on = 1'b1;
      bus.is_channel = 1'b1; bus.channel_number = '0;
      bus.channel_height = 9'd48; bus.channel_offset = '0;
      @(posedge clk); #1;
      bus.video_on = 1'b0;
      bus.hsync_in = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      check_eq("midline_rst_rgb", 32'(bus.rgb), 32'h000);
      check_eq("midline_rst_hsync", 32'(bus.hsync_out), 32'd1);
      reset = 1'b0;
      bus.hsync_in = 1'b1;
      bus.pixel_col = 10'd0;
      #1;
      check_eq("midline_rst_scroll", 32'(bus.sample_addr), 32'd0);
      @(posedge clk); #1;
      vid = 1'b1; ch = 0; ch_h = 48; ch_off = 0;
      render("after_rst_hi_rail", 10, 4, 12'h0F0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
